// File: rtl/rr_tag_scheduler_if.sv
// Request, transmit-engine, completion and return bus for rr_tag_scheduler.
interface rr_tag_scheduler_if #(
   parameter int unsigned NTAGS = 8
);
   localparam int unsigned TW = $clog2(NTAGS);

   logic          req_valid;
   logic          req_ready;
   logic [63:0]   req_addr;
   logic [1:0]    req_chan;

   logic          rr_valid;
   logic          rr_ready;
   logic [63:0]   rr_addr;
   logic [7:0]    rr_tag;

   logic          cpl_valid;
   logic [7:0]    cpl_tag;
   logic          cpl_last;

   logic          ret_valid;
   logic [1:0]    ret_chan;
   logic [TW-1:0] ret_tag;

   // Environment side: issues requests, accepts rr transfers, delivers completions
   modport master (
      output req_valid, req_addr, req_chan, rr_ready, cpl_valid, cpl_tag, cpl_last,
      input  req_ready, rr_valid, rr_addr, rr_tag, ret_valid, ret_chan, ret_tag
   );

   // Scheduler side
   modport slave (
      input  req_valid, req_addr, req_chan, rr_ready, cpl_valid, cpl_tag, cpl_last,
      output req_ready, rr_valid, rr_addr, rr_tag, ret_valid, ret_chan, ret_tag
   );
endinterface

// File: rtl/rr_tag_scheduler.sv
// Read-request scheduler: allocates PCIe tags from a fixed pool, frees them on
// final completion, reports the finished channel, and flags bad completions
// and stalled reads.
module rr_tag_scheduler #(
   parameter int unsigned NTAGS   = 8,
   parameter logic [15:0] TIMEOUT = 16'd65535
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                err_clear,
   rr_tag_scheduler_if.slave   bus,
   output logic [5:0]          outstanding,
   output logic                idle,
   output logic                err_unexpected,
   output logic                err_timeout
);
   localparam int unsigned TW = $clog2(NTAGS);
   localparam int unsigned CW = 2;
   localparam int unsigned OW = 6;
   localparam int unsigned WW = 16;

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t          state_q, state_d;
   logic [NTAGS-1:0] free_q, free_d;
   logic [CW-1:0]   chan_tbl_q [NTAGS];
   logic [63:0]     rr_addr_q;
   logic [7:0]      rr_tag_q;
   logic [OW-1:0]   outstanding_q;
   logic [WW-1:0]   wd_q, wd_d;
   logic            err_unexp_q, err_to_q;
   logic            ret_valid_q;
   logic [CW-1:0]   ret_chan_q;
   logic [TW-1:0]   ret_tag_q;

   logic            req_ready_c;
   logic            accept;
   logic [TW-1:0]   alloc_idx;
   logic            any_free;
   logic [TW-1:0]   cpl_idx;
   logic            cpl_in_range, cpl_busy, cpl_free_ev, cpl_bad;
   logic            wd_clr, to_hit;

   // Lowest-index free tag from the pre-edge mask
   always_comb begin
      alloc_idx = '0;
      for (int i = int'(NTAGS) - 1; i >= 0; i--) begin
         if (free_q[i]) alloc_idx = TW'(i);
      end
   end

   assign any_free = |free_q;

   // Completion classification
   always_comb begin
      cpl_idx      = bus.cpl_tag[TW-1:0];
      cpl_in_range = (bus.cpl_tag < 8'(NTAGS));
      cpl_busy     = cpl_in_range && !free_q[cpl_idx];
      cpl_free_ev  = bus.cpl_valid && bus.cpl_last && cpl_busy;
      cpl_bad      = bus.cpl_valid && !cpl_busy;
   end

   // FSM next state and ready; ready depends on registers and enable only
   always_comb begin
      state_d     = state_q;
      req_ready_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready_c = reset && enable && any_free;
            if (bus.req_valid && req_ready_c) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (bus.rr_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign accept = bus.req_valid && req_ready_c;

   // Next free mask; freed and allocated tags never coincide
   always_comb begin
      free_d = free_q;
      if (cpl_free_ev) free_d[cpl_idx]   = 1'b1;
      if (accept)      free_d[alloc_idx] = 1'b0;
   end

   // Watchdog next value and expiry detection (fires once on reaching TIMEOUT)
   always_comb begin
      wd_clr = (outstanding_q == '0) || bus.cpl_valid;
      if (wd_clr)                wd_d = '0;
      else if (wd_q == '1)       wd_d = wd_q;
      else                       wd_d = wd_q + WW'(1);
      to_hit = !wd_clr && (TIMEOUT != '0) && (wd_q == TIMEOUT - WW'(1));
   end

   // FSM state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Tag pool, channel table and held request
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         free_q    <= '1;
         rr_addr_q <= '0;
         rr_tag_q  <= '0;
         for (int i = 0; i < int'(NTAGS); i++) chan_tbl_q[i] <= '0;
      end else begin
         free_q <= free_d;
         if (accept) begin
            chan_tbl_q[alloc_idx] <= bus.req_chan;
            rr_addr_q             <= bus.req_addr;
            rr_tag_q              <= 8'(alloc_idx);
         end
      end
   end

   // Outstanding counter and watchdog
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outstanding_q <= '0;
         wd_q          <= '0;
      end else begin
         case ({accept, cpl_free_ev})
            2'b10:   outstanding_q <= outstanding_q + OW'(1);
            2'b01:   outstanding_q <= outstanding_q - OW'(1);
            default: outstanding_q <= outstanding_q;
         endcase
         wd_q <= wd_d;
      end
   end

   // Return pulse one cycle after a final completion
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ret_valid_q <= 1'b0;
         ret_chan_q  <= '0;
         ret_tag_q   <= '0;
      end else begin
         ret_valid_q <= cpl_free_ev;
         if (cpl_free_ev) begin
            ret_chan_q <= chan_tbl_q[cpl_idx];
            ret_tag_q  <= cpl_idx;
         end
      end
   end

   // Sticky errors; clear wins over a same-cycle set
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_unexp_q <= 1'b0;
         err_to_q    <= 1'b0;
      end else if (err_clear) begin
         err_unexp_q <= 1'b0;
         err_to_q    <= 1'b0;
      end else begin
         if (cpl_bad) err_unexp_q <= 1'b1;
         if (to_hit)  err_to_q    <= 1'b1;
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.rr_valid   = (state_q == S_ISSUE);
   assign bus.rr_addr    = rr_addr_q;
   assign bus.rr_tag     = rr_tag_q;
   assign bus.ret_valid  = ret_valid_q;
   assign bus.ret_chan   = ret_chan_q;
   assign bus.ret_tag    = ret_tag_q;
   assign outstanding    = outstanding_q;
   assign idle           = (state_q == S_IDLE) && (outstanding_q == '0);
   assign err_unexpected = err_unexp_q;
   assign err_timeout    = err_to_q;
endmodule

// File: tb/tb_rr_tag_scheduler.sv
// Directed bench for rr_tag_scheduler (NTAGS=8, TIMEOUT=100).
module tb_rr_tag_scheduler;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       err_clear = 1'b0;
   logic [5:0] outstanding;
   logic       idle, err_unexpected, err_timeout;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;
   int unsigned acc_cyc = 0;
   int unsigned prev_acc = 0;

   rr_tag_scheduler_if #(.NTAGS(8)) bus ();

   rr_tag_scheduler #(.NTAGS(8), .TIMEOUT(16'd100)) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .err_clear      (err_clear),
      .bus            (bus),
      .outstanding    (outstanding),
      .idle           (idle),
      .err_unexpected (err_unexpected),
      .err_timeout    (err_timeout)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present a request until accepted (bounded); returns one step after the accepting edge
   task automatic do_req(input logic [63:0] addr, input logic [1:0] chan);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      bus.req_chan  = chan;
      while (!bus.req_ready && n < 50) begin
         tick();
         n++;
      end
      if (!bus.req_ready) check("req_wait", 64'(bus.req_ready), 64'd1);
      tick();
      acc_cyc = cyc;
      bus.req_valid = 1'b0;
   endtask

   // One completion beat
   task automatic cpl(input logic [7:0] tag, input logic last);
      bus.cpl_valid = 1'b1;
      bus.cpl_tag   = tag;
      bus.cpl_last  = last;
      tick();
      bus.cpl_valid = 1'b0;
      bus.cpl_last  = 1'b0;
   endtask

   task automatic clear_err();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
   endtask

   logic [7:0] busy_tags [6] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6};
   logic [1:0] busy_chan [6] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd3, 2'd2};

   initial begin
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_chan  = '0;
      bus.rr_ready  = 1'b1;
      bus.cpl_valid = 1'b0;
      bus.cpl_tag   = '0;
      bus.cpl_last  = 1'b0;
      enable        = 1'b1;

      // Reset values with enable already high
      tick(); tick();
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rr_valid",  64'(bus.rr_valid), 64'd0);
      check("rst_ret_valid", 64'(bus.ret_valid), 64'd0);
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_idle", 64'(idle), 64'd1);
      check("rst_err_u", 64'(err_unexpected), 64'd0);
      check("rst_err_t", 64'(err_timeout), 64'd0);
      check("rst_rr_addr", bus.rr_addr, 64'd0);
      check("rst_rr_tag", 64'(bus.rr_tag), 64'd0);
      reset = 1'b1;
      tick();
      check("post_rst_ready", 64'(bus.req_ready), 64'd1);

      // Fill the pool: tags 0..7, channels i mod 4, spaced two cycles apart
      for (int i = 0; i < 8; i++) begin
         do_req(64'h1000_0000 + 64'(i) * 64'h200, 2'(i));
         check("fill_rr_valid", 64'(bus.rr_valid), 64'd1);
         check("fill_rr_tag", 64'(bus.rr_tag), 64'(i));
         check("fill_rr_addr", bus.rr_addr, 64'h1000_0000 + 64'(i) * 64'h200);
         check("fill_idle", 64'(idle), 64'd0);
         if (i > 0) check("fill_spacing", 64'(acc_cyc - prev_acc), 64'd2);
         if (i == 2) check("three_outstanding", 64'(outstanding), 64'd3);
         prev_acc = acc_cyc;
      end
      tick();
      check("full_req_ready", 64'(bus.req_ready), 64'd0);
      check("full_outstanding", 64'(outstanding), 64'd8);
      check("full_rr_valid", 64'(bus.rr_valid), 64'd0);

      // Free tag 5 (channel 1), then reuse it
      cpl(8'd5, 1'b1);
      check("t5_ret_valid", 64'(bus.ret_valid), 64'd1);
      check("t5_ret_chan", 64'(bus.ret_chan), 64'd1);
      check("t5_ret_tag", 64'(bus.ret_tag), 64'd5);
      check("t5_outstanding", 64'(outstanding), 64'd7);
      check("t5_req_ready", 64'(bus.req_ready), 64'd1);
      tick();
      check("t5_ret_pulse", 64'(bus.ret_valid), 64'd0);
      do_req(64'h2000_0000, 2'd3);
      check("t5_reuse_tag", 64'(bus.rr_tag), 64'd5);
      tick();
      check("t5_refull", 64'(outstanding), 64'd8);

      // Back-to-back completions on tags 2 (chan 2) and 7 (chan 3)
      bus.cpl_valid = 1'b1; bus.cpl_last = 1'b1; bus.cpl_tag = 8'd2;
      tick();
      check("b2b_ret0_valid", 64'(bus.ret_valid), 64'd1);
      check("b2b_ret0_tag", 64'(bus.ret_tag), 64'd2);
      check("b2b_ret0_chan", 64'(bus.ret_chan), 64'd2);
      bus.cpl_tag = 8'd7;
      tick();
      bus.cpl_valid = 1'b0; bus.cpl_last = 1'b0;
      check("b2b_ret1_valid", 64'(bus.ret_valid), 64'd1);
      check("b2b_ret1_tag", 64'(bus.ret_tag), 64'd7);
      check("b2b_ret1_chan", 64'(bus.ret_chan), 64'd3);
      tick();
      check("b2b_ret_end", 64'(bus.ret_valid), 64'd0);
      check("b2b_outstanding", 64'(outstanding), 64'd6);

      // Stall the transmit engine for 10 cycles
      bus.rr_ready = 1'b0;
      do_req(64'h3000_0000, 2'd0);
      bus.req_valid = 1'b1; bus.req_addr = 64'h3100_0000; bus.req_chan = 2'd1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("stall_rr_valid", 64'(bus.rr_valid), 64'd1);
         check("stall_rr_addr", bus.rr_addr, 64'h3000_0000);
         check("stall_rr_tag", 64'(bus.rr_tag), 64'd2);
         check("stall_req_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.rr_ready = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      check("stall_done_valid", 64'(bus.rr_valid), 64'd0);
      tick();
      check("stall_outstanding", 64'(outstanding), 64'd7);
      check("stall_no_extra", 64'(bus.rr_valid), 64'd0);

      // Unexpected completions and clearing
      clear_err();
      cpl(8'd3, 1'b1);
      check("t3_ret_tag", 64'(bus.ret_tag), 64'd3);
      check("t3_outstanding", 64'(outstanding), 64'd6);
      check("t3_no_err", 64'(err_unexpected), 64'd0);
      cpl(8'd3, 1'b1);
      check("free_cpl_err", 64'(err_unexpected), 64'd1);
      check("free_cpl_no_ret", 64'(bus.ret_valid), 64'd0);
      check("free_cpl_outst", 64'(outstanding), 64'd6);
      clear_err();
      check("err_u_cleared", 64'(err_unexpected), 64'd0);
      cpl(8'd9, 1'b0);
      check("range_cpl_err", 64'(err_unexpected), 64'd1);
      check("range_cpl_outst", 64'(outstanding), 64'd6);
      clear_err();
      err_clear = 1'b1;
      cpl(8'd9, 1'b1);
      err_clear = 1'b0;
      check("clear_priority", 64'(err_unexpected), 64'd0);
      tick();
      check("clear_stays", 64'(err_unexpected), 64'd0);

      // Drain every busy tag
      for (int i = 0; i < 6; i++) begin
         cpl(busy_tags[i], 1'b1);
         check("drain_ret_tag", 64'(bus.ret_tag), 64'(busy_tags[i]));
         check("drain_ret_chan", 64'(bus.ret_chan), 64'(busy_chan[i]));
      end
      check("drain_outstanding", 64'(outstanding), 64'd0);
      check("drain_idle", 64'(idle), 64'd1);
      clear_err();

      // Watchdog: one read, no completions
      do_req(64'h4000_0000, 2'd0);
      while (cyc < acc_cyc + 99) tick();
      check("wd_before", 64'(err_timeout), 64'd0);
      tick();
      check("wd_at_100", 64'(err_timeout), 64'd1);
      clear_err();
      tick(); tick();
      check("wd_cleared_stays", 64'(err_timeout), 64'd0);
      cpl(8'd0, 1'b1);
      check("wd_drain", 64'(outstanding), 64'd0);

      // Watchdog restarted by a non-last completion at cycle 50
      do_req(64'h5000_0000, 2'd1);
      while (cyc < acc_cyc + 49) tick();
      cpl(8'd0, 1'b0);
      while (cyc < acc_cyc + 149) tick();
      check("wd_delay_before", 64'(err_timeout), 64'd0);
      tick();
      check("wd_delay_at_150", 64'(err_timeout), 64'd1);
      check("wd_delay_no_unexp", 64'(err_unexpected), 64'd0);
      cpl(8'd0, 1'b1);
      clear_err();

      // Accept in the same cycle as freeing the last busy tag
      do_req(64'h6000_0000, 2'd2);
      tick();
      check("same_pre_outst", 64'(outstanding), 64'd1);
      bus.rr_ready  = 1'b0;
      bus.req_valid = 1'b1; bus.req_addr = 64'h6100_0000; bus.req_chan = 2'd3;
      bus.cpl_valid = 1'b1; bus.cpl_tag = 8'd0; bus.cpl_last = 1'b1;
      tick();
      bus.req_valid = 1'b0; bus.cpl_valid = 1'b0; bus.cpl_last = 1'b0;
      check("same_rr_tag", 64'(bus.rr_tag), 64'd1);
      check("same_outstanding", 64'(outstanding), 64'd1);
      check("same_ret_valid", 64'(bus.ret_valid), 64'd1);
      check("same_ret_tag", 64'(bus.ret_tag), 64'd0);
      check("same_rr_valid", 64'(bus.rr_valid), 64'd1);

      // Reset in the middle of ISSUE
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_rr_valid", 64'(bus.rr_valid), 64'd0);
      check("mid_rst_idle", 64'(idle), 64'd1);
      check("mid_rst_outst", 64'(outstanding), 64'd0);
      check("mid_rst_ready", 64'(bus.req_ready), 64'd0);
      check("mid_rst_ret", 64'(bus.ret_valid), 64'd0);
      tick();
      reset = 1'b1;
      bus.rr_ready = 1'b1;
      tick();
      do_req(64'h7000_0000, 2'd1);
      check("post_rst_tag", 64'(bus.rr_tag), 64'd0);
      tick();
      check("post_rst_outst", 64'(outstanding), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/rr_tag_scheduler.md
# rr_tag_scheduler

Read-request scheduler between the DMA read-channel mux and the PCIe transmit engine's read-request port. It allocates PCIe tags from a fixed pool and holds back requests while every tag is outstanding. On each final completion it frees the tag and reports which channel finished. It also detects unexpected completions and stalled reads. Each request is one 128-DW (512-byte) memory read, so the pool size also bounds completion-buffer occupancy.

## Interface
- NTAGS, 8, tag pool size; power of two, 2..32; tag index width TW = log2(NTAGS)
- TIMEOUT, 65535, cycles without any completion, while reads are outstanding, before err_timeout sets; 16-bit
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low (0 = reset); one clock; reset is asynchronous and active-low
- enable  in  1  1 = accept new requests
- req_valid  in  1  upstream read request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  64  request byte address, 512-byte aligned
- req_chan  in  2  requesting channel id
- rr_valid  out  1  request to transmit engine valid
- rr_ready  in  1  transfer when rr_valid && rr_ready
- rr_addr  out  64  registered copy of req_addr
- rr_tag  out  8  {(8-TW)'b0, tag index}
- cpl_valid  in  1  completion beat from receive path
- cpl_tag  in  8  tag of completion
- cpl_last  in  1  final completion for this tag
- ret_valid  out  1  one-cycle pulse: read finished
- ret_chan  out  2  channel of finished read
- ret_tag  out  TW  freed tag index
- outstanding  out  6  tags currently in use
- idle  out  1  no request held and outstanding == 0
- err_unexpected  out  1  sticky: completion for a free tag or for tag index >= NTAGS
- err_timeout  out  1  sticky: watchdog expired
- err_clear  in  1  clears both sticky errors

## Operation
- Free mask: NTAGS bits, all ones at reset. The per-tag table stores the channel (2 bits).
- FSM states:
  - IDLE: req_ready = enable && (free != 0). This is combinational from registers only, with no path from req_valid. On acceptance:
    - pick the lowest-index free tag;
    - clear its free bit;
    - store req_chan in its table entry;
    - load rr_addr/rr_tag;
    - go to ISSUE.
  - ISSUE: rr_valid = 1. rr_addr and rr_tag hold stable. On rr_ready, go to IDLE. In ISSUE, req_ready = 0.
- Completion handling:
  - cpl_valid && cpl_last on a busy tag: set its free bit; next cycle pulse ret_valid with ret_chan = table[tag] and ret_tag = tag.
  - cpl_valid && !cpl_last: no tag state change. It still restarts the watchdog.
  - cpl_valid on a free tag, or on cpl_tag >= NTAGS: set err_unexpected; no state change; no ret_valid.
- outstanding = NTAGS − popcount(free), held as a registered counter: +1 on acceptance, −1 on a valid free, and unchanged when both happen in the same cycle.
- Watchdog: a 16-bit counter.
  - Clears when outstanding == 0 or on any cpl_valid.
  - Otherwise increments, saturating.
  - When it reaches TIMEOUT, set err_timeout.
  - Tags are never reclaimed by timeout; software resets the block.
- enable deasserting in ISSUE: the held request still completes. enable gates acceptance only.
- err_clear has priority over a same-cycle error set. Errors stay clear until a new error event.

## Timing
- Reset values:
  - rr_valid 0, req_ready 0 (forced low while reset is asserted);
  - ret_valid 0, outstanding 0, idle 1;
  - both errors 0, free mask all ones, FSM IDLE, watchdog 0;
  - rr_addr and rr_tag 0.
- Accept at edge N: rr_valid is high from cycle N+1. The earliest next acceptance is the cycle after the rr handshake, so the peak rate is one request per 2 cycles.
- Free and allocate in the same cycle: allocation uses the pre-edge free mask. A tag freed at edge N is allocatable from cycle N+1.
- Completion with cpl_last at edge N: ret_valid is high for cycle N+1 only. Back-to-back completions on different tags give back-to-back ret_valid pulses.
- Reset asserted mid-operation: all state returns to reset values immediately. A held rr request is dropped, and in-flight tags are forgotten.

## Test plan
- Reset, enable=1, issue 3 requests to chan 0, 1, 2 with rr_ready held 1 → rr_tag 0, 1, 2; outstanding = 3; requests spaced 2 cycles apart.
- NTAGS=8: issue 8 requests without completions → req_ready=0 after the 8th. Send cpl_last for tag 5 → ret_valid pulse with ret_chan = chan of tag 5, ret_tag=5; the next request is issued with tag 5.
- rr_ready held 0 for 10 cycles → rr_valid, rr_addr and rr_tag stable, req_ready=0. After rr_ready rises, one transfer and back to IDLE.
- Completion for free tag 3, then for tag 9 → err_unexpected=1 and outstanding unchanged. Then err_clear → err_unexpected=0.
- TIMEOUT=100, one outstanding read with no completions → err_timeout set on cycle 100 after issue. A non-last cpl_valid at cycle 50 delays the set by 50 cycles.
- Accept a request in the same cycle as cpl_last for the last busy tag → outstanding unchanged; the new request does not receive the just-freed tag. Assert reset mid-ISSUE → rr_valid=0, idle=1, outstanding=0 immediately.
